debug_ram_master: RTL
=====================

Name: debug_ram_master

Overview:
- Host-side initiator for the core's debug memory ports. It drives the second port (A2/WD2/WE2) of the data RAM and the instruction RAM, and collects read data from RD2.
- Sits between a host command source (UART bridge or testbench loader) and the core top.
- Converts single-word write, single-word read and burst-dump commands into RAM port cycles with valid/ready handshakes on both the command and the response side.

Parameters:
- LEN_W, 8, width of burst length field; max dump = 2^LEN_W-1 words
- RD_LAT, 1, RAM port-2 read latency in cycles (1..3) from A2 stable to RD2 valid

Ports:
- CPU_CLK  input  1  clock
- CPU_RST  input  1  reset; synchronous, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block accepts command this cycle
- cmd_op  input  2  00 write word, 01 read word, 10 dump burst, 11 reserved (accepted, ignored)
- cmd_sel  input  1  0 data RAM, 1 instruction RAM
- cmd_addr  input  32  byte address; bits [1:0] forced to 0
- cmd_wdata  input  32  write data
- cmd_be  input  4  byte enables for write
- cmd_len  input  LEN_W  word count for dump
- rsp_valid  output  1  response word available
- rsp_ready  input  1  host consumes response
- rsp_data  output  32  read word
- rsp_addr  output  32  word-aligned address of rsp_data
- rsp_last  output  1  final word of read/dump
- busy  output  1  not in IDLE
- CPU_Debug_DataRAM_A2  output  32  data RAM port-2 address
- CPU_Debug_DataRAM_WD2  output  32  data RAM port-2 write data
- CPU_Debug_DataRAM_WE2  output  4  data RAM port-2 byte write enables
- CPU_Debug_DataRAM_RD2  input  32  data RAM port-2 read data
- CPU_Debug_InstRAM_A2  output  32  instruction RAM port-2 address
- CPU_Debug_InstRAM_WD2  output  32  instruction RAM port-2 write data
- CPU_Debug_InstRAM_WE2  output  4  instruction RAM port-2 byte write enables
- CPU_Debug_InstRAM_RD2  input  32  instruction RAM port-2 read data

Behaviour:
- Reset (CPU_RST high at a CPU_CLK edge) forces: state IDLE, cmd_ready=0 in that cycle, rsp_valid=0, rsp_last=0, rsp_data=0, rsp_addr=0, busy=0, all A2/WD2=0, all WE2=0.
- Reset mid-burst abandons the burst. No further WE2 or rsp_valid is produced.
- cmd_ready=1 only in IDLE and not in reset. A command is accepted when cmd_valid&cmd_ready, and all cmd_* fields are latched on acceptance.
- Only the selected RAM is driven. The unselected RAM's WE2=0 and its A2/WD2 hold their last value.
- State machine:
  - IDLE -> WRITE (op 00) | ISSUE (op 01, or op 10 with len!=0) | IDLE (op 10 with len=0, or op 11; no response).
  - WRITE: for exactly one cycle, A2=addr, WD2=wdata, WE2=cmd_be. Next state IDLE. No response. The write costs 2 cycles accept-to-ready.
  - ISSUE: A2=addr, WE2=0; load wait counter = RD_LAT-1. Next state WAIT.
  - WAIT: A2 held. When the counter reaches 0, sample the selected RD2 into rsp_data and set rsp_addr=addr. Go to RESP with rsp_valid=1.
  - RESP: rsp_valid, rsp_data, rsp_addr and rsp_last are held stable until rsp_ready. rsp_last=1 when the remaining count is 1 (op 01 uses count=1). On the handshake: count-1 and addr+4. If count becomes 0, go to IDLE; otherwise go to ISSUE.
- Address arithmetic is 32-bit modulo. Wrap past 0xFFFFFFFC goes to 0x00000000 silently.
- Throughput for a dump with rsp_ready held 1: one word every RD_LAT+2 cycles. The first rsp_valid appears RD_LAT+1 cycles after acceptance.
- busy = (state != IDLE).
- WE2 is never nonzero outside WRITE.

Optional Feature:
- Macro: DBG_WRITE_VERIFY_EN.
- Defined: the WRITE state is followed by a read-back of the same address through ISSUE/WAIT. The response uses rsp_last=1, rsp_data = read-back word, and an extra output port verify_err (1 bit).
  - verify_err = 1 if any byte enabled in cmd_be differs from cmd_wdata.
  - verify_err is valid with rsp_valid and is 0 at reset.
- Undefined: the verify_err port does not exist. Writes produce no response, as specified above.

Test Plan:
- Reset: hold CPU_RST 2 cycles mid-dump -> next cycle rsp_valid=0, all WE2=0, busy=0; cmd_ready=1 one cycle after reset release.
- Write: op 00, sel 1, addr 0x00000013, wdata 0xDEADBEEF, be 0xF -> InstRAM A2=0x00000010, WD2=0xDEADBEEF, WE2=0xF for exactly 1 cycle; DataRAM WE2 stays 0; cmd_ready back after 2 cycles.
- Read: op 01, sel 0, addr 0x40, RAM word 0x12345678, RD_LAT=1 -> rsp_valid 2 cycles after accept, rsp_data=0x12345678, rsp_addr=0x40, rsp_last=1.
- Dump with backpressure: op 10, len 3, addr 0x100, rsp_ready low 5 cycles on word 2 -> responses at 0x100, 0x104, 0x108; data held stable while stalled; rsp_last only on 0x108.
- Wrap and zero length: op 10, len 2, addr 0xFFFFFFFC -> rsp_addr 0xFFFFFFFC then 0x00000000. Op 10, len 0 -> no rsp_valid, cmd_ready returns next cycle.
- Verify (macro defined): write be 0x3 while the RAM model ignores byte 1 -> rsp_valid with verify_err=1. With a correct RAM model -> verify_err=0.

Source files
------------

// File: rtl/debug_ram_master.sv
`default_nettype none
// ============================================================================
//  Module   : debug_ram_master
//  Brief    : Host-side initiator for the port-2 debug paths of the data and
//             instruction RAMs. It turns write, read and burst-dump commands
//             into RAM port cycles and returns read words over a valid/ready
//             response channel.
//  Option   : DBG_WRITE_VERIFY_EN - every write is followed by a read-back of
//             the same word; the response carries verify_err.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_ram_master #(
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_sel,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_be,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [31:0]      rsp_addr,
    output logic             rsp_last,
    output logic             busy,
`ifdef DBG_WRITE_VERIFY_EN
    output logic             verify_err,
`endif
    output logic [31:0]      CPU_Debug_DataRAM_A2,
    output logic [31:0]      CPU_Debug_DataRAM_WD2,
    output logic [3:0]       CPU_Debug_DataRAM_WE2,
    input  logic [31:0]      CPU_Debug_DataRAM_RD2,
    output logic [31:0]      CPU_Debug_InstRAM_A2,
    output logic [31:0]      CPU_Debug_InstRAM_WD2,
    output logic [3:0]       CPU_Debug_InstRAM_WE2,
    input  logic [31:0]      CPU_Debug_InstRAM_RD2
);

    localparam logic [1:0] c_op_write = 2'b00;
    localparam logic [1:0] c_op_read  = 2'b01;
    localparam logic [1:0] c_op_dump  = 2'b10;
    localparam logic [1:0] c_wait_init = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic [31:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [1:0]         wait_q, wait_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [31:0]        rsp_addr_q, rsp_addr_d;
    logic               rsp_last_q, rsp_last_d;
    logic               busy_q, busy_d;
    logic [31:0]        d_a2_q, d_a2_d, d_wd2_q, d_wd2_d;
    logic [3:0]         d_we2_q, d_we2_d;
    logic [31:0]        i_a2_q, i_a2_d, i_wd2_q, i_wd2_d;
    logic [3:0]         i_we2_q, i_we2_d;
`ifdef DBG_WRITE_VERIFY_EN
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               verify_err_q, verify_err_d;
    logic [31:0]        w_be_mask;
`endif

    logic               w_load_a2;
    logic               w_load_sel;
    logic [31:0]        w_load_addr;
    logic [31:0]        w_rd2;

    assign w_rd2 = sel_q ? CPU_Debug_InstRAM_RD2 : CPU_Debug_DataRAM_RD2;
`ifdef DBG_WRITE_VERIFY_EN
    assign w_be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
`endif

    // Next-state, datapath and port-2 drive computation
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        count_d     = count_q;
        wait_d      = wait_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_last_d  = rsp_last_q;
        d_a2_d      = d_a2_q;
        d_wd2_d     = d_wd2_q;
        i_a2_d      = i_a2_q;
        i_wd2_d     = i_wd2_q;
        // Byte enables are a one-cycle pulse: only set on entry to WRITE
        d_we2_d     = 4'h0;
        i_we2_d     = 4'h0;
        w_load_a2   = 1'b0;
        w_load_sel  = sel_q;
        w_load_addr = addr_q;
`ifdef DBG_WRITE_VERIFY_EN
        wdata_d      = wdata_q;
        be_d         = be_q;
        verify_err_d = verify_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    sel_d       = cmd_sel;
                    addr_d      = {cmd_addr[31:2], 2'b00};
                    w_load_sel  = cmd_sel;
                    w_load_addr = {cmd_addr[31:2], 2'b00};
`ifdef DBG_WRITE_VERIFY_EN
                    wdata_d = cmd_wdata;
                    // Reads keep a zero mask so they never flag a mismatch
                    be_d    = (cmd_op == c_op_write) ? cmd_be : 4'h0;
`endif
                    case (cmd_op)
                        c_op_write: begin
                            state_d   = S_WRITE;
                            w_load_a2 = 1'b1;
                            if (cmd_sel) begin
                                i_wd2_d = cmd_wdata;
                                i_we2_d = cmd_be;
                            end else begin
                                d_wd2_d = cmd_wdata;
                                d_we2_d = cmd_be;
                            end
                        end
                        c_op_read: begin
                            count_d   = LEN_W'(1);
                            state_d   = S_ISSUE;
                            w_load_a2 = 1'b1;
                        end
                        c_op_dump: begin
                            if (cmd_len != '0) begin
                                count_d   = cmd_len;
                                state_d   = S_ISSUE;
                                w_load_a2 = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_WRITE: begin
`ifdef DBG_WRITE_VERIFY_EN
                // Address is already on A2; read the same word back
                count_d = LEN_W'(1);
                state_d = S_ISSUE;
`else
                state_d = S_IDLE;
`endif
            end
            S_ISSUE: begin
                wait_d  = c_wait_init;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 2'd0) begin
                    rsp_data_d  = w_rd2;
                    rsp_addr_d  = addr_q;
                    rsp_last_d  = (count_q == LEN_W'(1));
                    rsp_valid_d = 1'b1;
`ifdef DBG_WRITE_VERIFY_EN
                    verify_err_d = |((w_rd2 ^ wdata_q) & w_be_mask);
`endif
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    count_d     = count_q - LEN_W'(1);
                    addr_d      = addr_q + 32'd4;
                    if (count_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_ISSUE;
                        w_load_a2   = 1'b1;
                        w_load_addr = addr_q + 32'd4;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Only the selected RAM's address moves; the other one holds
        if (w_load_a2) begin
            if (w_load_sel) begin
                i_a2_d = w_load_addr;
            end else begin
                d_a2_d = w_load_addr;
            end
        end
    end

    assign cmd_ready_d = (state_d == S_IDLE);
    assign busy_d      = (state_d != S_IDLE);

    // State and registered outputs
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            addr_q      <= 32'h0;
            count_q     <= '0;
            wait_q      <= 2'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_addr_q  <= 32'h0;
            rsp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            d_a2_q      <= 32'h0;
            d_wd2_q     <= 32'h0;
            d_we2_q     <= 4'h0;
            i_a2_q      <= 32'h0;
            i_wd2_q     <= 32'h0;
            i_we2_q     <= 4'h0;
`ifdef DBG_WRITE_VERIFY_EN
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            verify_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            wait_q      <= wait_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_last_q  <= rsp_last_d;
            busy_q      <= busy_d;
            d_a2_q      <= d_a2_d;
            d_wd2_q     <= d_wd2_d;
            d_we2_q     <= d_we2_d;
            i_a2_q      <= i_a2_d;
            i_wd2_q     <= i_wd2_d;
            i_we2_q     <= i_we2_d;
`ifdef DBG_WRITE_VERIFY_EN
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            verify_err_q <= verify_err_d;
`endif
        end
    end

    assign cmd_ready             = cmd_ready_q;
    assign rsp_valid             = rsp_valid_q;
    assign rsp_data              = rsp_data_q;
    assign rsp_addr              = rsp_addr_q;
    assign rsp_last              = rsp_last_q;
    assign busy                  = busy_q;
    assign CPU_Debug_DataRAM_A2  = d_a2_q;
    assign CPU_Debug_DataRAM_WD2 = d_wd2_q;
    assign CPU_Debug_DataRAM_WE2 = d_we2_q;
    assign CPU_Debug_InstRAM_A2  = i_a2_q;
    assign CPU_Debug_InstRAM_WD2 = i_wd2_q;
    assign CPU_Debug_InstRAM_WE2 = i_we2_q;
`ifdef DBG_WRITE_VERIFY_EN
    assign verify_err            = verify_err_q;
`endif

endmodule
`default_nettype wire
